// File: rtl/qqspi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : qqspi_pkg
// Brief   : Shared types and constants for the two-port qqspi arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package qqspi_pkg;

   // Arbiter sequencing: wait for a request, wait for qqspi, answer requester
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   // Default memory windows (start inclusive, end exclusive)
   localparam logic [31:0] DEF_FLASH_START = 32'h2000_0000;
   localparam logic [31:0] DEF_FLASH_END   = 32'h2100_0000;
   localparam logic [31:0] DEF_PSRAM_START = 32'h8000_0000;
   localparam logic [31:0] DEF_PSRAM_END   = 32'h8100_0000;

   // Latched request; addr is already the qqspi word address
   typedef struct packed {
      logic [22:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mem_req_t;

   // Half-open window test [lo, hi)
   function automatic logic in_window(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
      return (a >= lo) && (a < hi);
   endfunction

   // One-hot per-port mask for a port index
   function automatic logic [1:0] port_mask(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage
`default_nettype wire

// File: rtl/qqspi_arbiter_rr_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-input round-robin picker (combinational). On a tie the port
//           that was not served last wins.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant,
   output logic       any
);

   // Pick the single requester, or alternate away from last on a tie
   always_comb begin
      any = |req;
      if (req == 2'b11) begin
         grant = ~last;
      end else begin
         grant = req[1];
      end
   end

endmodule
`default_nettype wire

// File: rtl/qqspi_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : qqspi_arbiter
// Brief   : Shares one qqspi controller between two requesters. Round-robin
//           grant locked for the whole transaction, flash/PSRAM decode, and
//           local fault response for flash writes and unmapped addresses.
// Revision: 1.0 - initial release
// ============================================================================
module qqspi_arbiter
   import qqspi_pkg::*;
#(
   parameter logic [31:0] FLASH_START = DEF_FLASH_START,
   parameter logic [31:0] FLASH_END   = DEF_FLASH_END,
   parameter logic [31:0] PSRAM_START = DEF_PSRAM_START,
   parameter logic [31:0] PSRAM_END   = DEF_PSRAM_END
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  s_valid,
   input  logic [31:0] s_addr0,
   input  logic [31:0] s_addr1,
   input  logic [31:0] s_wdata0,
   input  logic [31:0] s_wdata1,
   input  logic [3:0]  s_wstrb0,
   input  logic [3:0]  s_wstrb1,
   output logic [1:0]  s_ready,
   output logic [1:0]  s_fault,
   output logic [31:0] s_rdata,
   output logic        m_valid,
   output logic [22:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_psram,
   input  logic        m_ready,
   input  logic [31:0] m_rdata,
   output logic        grant
);

   arb_state_t  state_q,   state_d;
   logic        last_q,    last_d;
   logic        grant_q,   grant_d;
   mem_req_t    req_q,     req_d;
   logic        m_valid_q, m_valid_d;
   logic        m_psram_q, m_psram_d;
   logic [1:0]  s_ready_q, s_ready_d;
   logic [1:0]  s_fault_q, s_fault_d;
   logic [31:0] s_rdata_q, s_rdata_d;

   logic        arb_grant;
   logic        arb_any;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_wstrb;
   logic        sel_flash;
   logic        sel_psram;

   rr_arb2 u_rr_arb2 (
      .req   (s_valid),
      .last  (last_q),
      .grant (arb_grant),
      .any   (arb_any)
   );

   // Mux the winning port's request and decode its target window
   always_comb begin
      sel_addr  = arb_grant ? s_addr1  : s_addr0;
      sel_wdata = arb_grant ? s_wdata1 : s_wdata0;
      sel_wstrb = arb_grant ? s_wstrb1 : s_wstrb0;
      sel_flash = in_window(sel_addr, FLASH_START, FLASH_END);
      sel_psram = in_window(sel_addr, PSRAM_START, PSRAM_END);
   end

   // Next-state logic: grant/latch in IDLE, wait for qqspi in BUSY,
   // one-cycle response in RESP. Response outputs default low every cycle.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      req_d     = req_q;
      m_valid_d = m_valid_q;
      m_psram_d = m_psram_q;
      s_ready_d = 2'b00;
      s_fault_d = 2'b00;
      s_rdata_d = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               grant_d     = arb_grant;
               last_d      = arb_grant;
               req_d.addr  = {1'b0, sel_addr[23:2]};
               req_d.wdata = sel_wdata;
               req_d.wstrb = sel_wstrb;
               // PSRAM is checked first so it accepts writes even if the
               // windows were ever configured to overlap
               if (sel_psram) begin
                  m_valid_d = 1'b1;
                  m_psram_d = 1'b1;
                  state_d   = ST_BUSY;
               end else if (sel_flash && (sel_wstrb == 4'b0000)) begin
                  m_valid_d = 1'b1;
                  m_psram_d = 1'b0;
                  state_d   = ST_BUSY;
               end else begin
                  m_psram_d = 1'b0;
                  s_ready_d = port_mask(arb_grant);
                  s_fault_d = port_mask(arb_grant);
                  state_d   = ST_RESP;
               end
            end
         end
         ST_BUSY: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               s_ready_d = port_mask(grant_q);
               // Writes return zero regardless of what qqspi drives
               s_rdata_d = (req_q.wstrb == 4'b0000) ? m_rdata : 32'h0;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         last_q    <= 1'b1;
         grant_q   <= 1'b0;
         req_q     <= '0;
         m_valid_q <= 1'b0;
         m_psram_q <= 1'b0;
         s_ready_q <= 2'b00;
         s_fault_q <= 2'b00;
         s_rdata_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         req_q     <= req_d;
         m_valid_q <= m_valid_d;
         m_psram_q <= m_psram_d;
         s_ready_q <= s_ready_d;
         s_fault_q <= s_fault_d;
         s_rdata_q <= s_rdata_d;
      end
   end

   assign s_ready = s_ready_q;
   assign s_fault = s_fault_q;
   assign s_rdata = s_rdata_q;
   assign m_valid = m_valid_q;
   assign m_addr  = req_q.addr;
   assign m_wdata = req_q.wdata;
   assign m_wstrb = req_q.wstrb;
   assign m_psram = m_psram_q;
   assign grant   = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_qqspi_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_qqspi_arbiter
// Brief   : Directed, table-driven bench for qqspi_arbiter with a small
//           qqspi latency model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_qqspi_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  s_valid;
   logic [31:0] s_addr0, s_addr1, s_wdata0, s_wdata1;
   logic [3:0]  s_wstrb0, s_wstrb1;
   logic [1:0]  s_ready, s_fault;
   logic [31:0] s_rdata;
   logic        m_valid;
   logic [22:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_psram;
   logic        m_ready;
   logic [31:0] m_rdata;
   logic        grant;

   int n_tests = 0;
   int n_fail  = 0;

   // qqspi model controls
   int          model_lat   = 1;
   logic [31:0] model_rdata = 32'h0;
   logic        spurious    = 1'b0;

   typedef struct {
      logic        port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          lat;
      logic [31:0] mrdata;
      logic        exp_fault;
      logic        exp_psram;
      logic [22:0] exp_maddr;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[10];

   qqspi_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_addr0  (s_addr0),
      .s_addr1  (s_addr1),
      .s_wdata0 (s_wdata0),
      .s_wdata1 (s_wdata1),
      .s_wstrb0 (s_wstrb0),
      .s_wstrb1 (s_wstrb1),
      .s_ready  (s_ready),
      .s_fault  (s_fault),
      .s_rdata  (s_rdata),
      .m_valid  (m_valid),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_wstrb  (m_wstrb),
      .m_psram  (m_psram),
      .m_ready  (m_ready),
      .m_rdata  (m_rdata),
      .grant    (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // qqspi model: m_ready pulses model_lat cycles after m_valid is first seen
   initial begin : qqspi_model
      int cnt;
      cnt     = -1;
      m_ready = 1'b0;
      m_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         m_ready = 1'b0;
         m_rdata = 32'h0;
         if (!rst_n || !m_valid) begin
            cnt = -1;
            if (spurious) begin
               m_ready  = 1'b1;
               m_rdata  = 32'hBAD0_BAD0;
               spurious = 1'b0;
            end
         end else begin
            if (cnt < 0) cnt = model_lat;
            if (cnt == 0) begin
               m_ready = 1'b1;
               m_rdata = model_rdata;
               cnt     = -1;
            end else begin
               cnt = cnt - 1;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_port(input logic p, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
      if (p) begin
         s_addr1 = a; s_wdata1 = d; s_wstrb1 = s; s_valid[1] = 1'b1;
      end else begin
         s_addr0 = a; s_wdata0 = d; s_wstrb0 = s; s_valid[0] = 1'b1;
      end
   endtask

   // One single-port transaction: checks response, latency, downstream
   // request and absence of a second service after valid is dropped
   task automatic run_vec(input vec_t v, input int idx);
      int          mv_first, cyc;
      logic        got, other, flt, gnt, extra;
      logic [31:0] rd, cap_wdata;
      logic [22:0] cap_maddr;
      logic        cap_psram;
      logic [3:0]  cap_wstrb;
      string       tag;
      tag = $sformatf("v%0d", idx);
      mv_first = 0; cyc = 0; got = 0; other = 0; flt = 0; gnt = 0; rd = 0;
      cap_maddr = 0; cap_psram = 0; cap_wstrb = 0; cap_wdata = 0;
      model_lat   = v.lat;
      model_rdata = v.mrdata;
      @(posedge clk); #1;
      drive_port(v.port, v.addr, v.wdata, v.wstrb);
      for (int c = 1; c <= 100 && !got; c++) begin
         @(negedge clk);
         if (m_valid && mv_first == 0) begin
            mv_first  = c;
            cap_maddr = m_addr;
            cap_psram = m_psram;
            cap_wstrb = m_wstrb;
            cap_wdata = m_wdata;
         end
         if (s_ready[!v.port]) other = 1'b1;
         if (s_ready[v.port]) begin
            got = 1'b1; cyc = c; flt = s_fault[v.port]; rd = s_rdata; gnt = grant;
         end
      end
      check({tag, " ready_seen"}, 32'(got), 32'd1);
      check({tag, " latency"}, cyc, v.exp_fault ? 32'd2 : 32'(v.lat + 3));
      check({tag, " fault"}, 32'(flt), 32'(v.exp_fault));
      check({tag, " rdata"}, rd, v.exp_rdata);
      check({tag, " grant"}, 32'(gnt), 32'(v.port));
      check({tag, " other_port_quiet"}, 32'(other), 32'd0);
      if (v.exp_fault) begin
         check({tag, " m_valid_never"}, mv_first, 32'd0);
      end else begin
         check({tag, " m_valid_at_N+1"}, mv_first, 32'd2);
         check({tag, " m_addr"}, 32'(cap_maddr), 32'(v.exp_maddr));
         check({tag, " m_psram"}, 32'(cap_psram), 32'(v.exp_psram));
         check({tag, " m_wstrb"}, 32'(cap_wstrb), 32'(v.wstrb));
         check({tag, " m_wdata"}, cap_wdata, v.wdata);
      end
      // valid was held through the s_ready cycle; drop it after that edge
      @(posedge clk); #1;
      s_valid[v.port] = 1'b0;
      extra = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (s_ready != 2'b00 || m_valid) extra = 1'b1;
      end
      check({tag, " no_double_serve"}, 32'(extra), 32'd0);
   endtask

   initial begin : main
      int   seq[4];
      int   npulse, cnt0, cnt1;
      logic bad;

      //                port  addr          wdata         wstrb  lat mrdata        flt psr maddr        rdata
      vecs[0] = '{1'b0, 32'h2000_0010, 32'h0,        4'b0000, 20, 32'hDEAD_BEEF, 0, 0, 23'h000004, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 32'h8000_0100, 32'h1234_5678, 4'b0011, 3, 32'hFFFF_FFFF, 0, 1, 23'h000040, 32'h0};
      vecs[2] = '{1'b0, 32'h2000_0000, 32'hCAFE_0000, 4'b1111, 5, 32'h1111_1111, 1, 0, 23'h0,      32'h0};
      vecs[3] = '{1'b0, 32'h0000_0000, 32'h0,        4'b0000, 5, 32'h2222_2222, 1, 0, 23'h0,      32'h0};
      vecs[4] = '{1'b1, 32'h20FF_FFFC, 32'h0,        4'b0000, 2, 32'hA5A5_0001, 0, 0, 23'h3FFFFF, 32'hA5A5_0001};
      vecs[5] = '{1'b0, 32'h2100_0000, 32'h0,        4'b0000, 2, 32'h3333_3333, 1, 0, 23'h0,      32'h0};
      vecs[6] = '{1'b1, 32'h80FF_FFFC, 32'h0,        4'b0000, 4, 32'h5A5A_0002, 0, 1, 23'h3FFFFF, 32'h5A5A_0002};
      vecs[7] = '{1'b0, 32'h8100_0000, 32'h0BAD_F00D, 4'b1000, 2, 32'h4444_4444, 1, 0, 23'h0,      32'h0};
      vecs[8] = '{1'b1, 32'h7FFF_FFFC, 32'h0,        4'b0000, 2, 32'h5555_5555, 1, 0, 23'h0,      32'h0};
      vecs[9] = '{1'b0, 32'h8000_0000, 32'h0,        4'b0000, 1, 32'h0BAD_CAFE, 0, 1, 23'h000000, 32'h0BAD_CAFE};

      rst_n = 1'b0;
      s_valid = 2'b00;
      s_addr0 = 0; s_addr1 = 0; s_wdata0 = 0; s_wdata1 = 0; s_wstrb0 = 0; s_wstrb1 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset m_valid", 32'(m_valid), 32'd0);
      check("reset m_addr", 32'(m_addr), 32'd0);
      check("reset m_wdata_wstrb_psram", {m_wdata[27:0], m_wstrb} | 32'(m_psram), 32'd0);
      check("reset s_ready_fault", 32'({s_ready, s_fault}), 32'd0);
      check("reset s_rdata", s_rdata, 32'd0);
      check("reset grant", 32'(grant), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // m_ready outside BUSY must be ignored
      spurious = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (s_ready != 2'b00 || m_valid) bad = 1'b1;
      end
      check("spurious m_ready ignored", 32'(bad), 32'd0);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Last served port is 0; start a long port-0 read and reset in BUSY
      model_lat = 20;
      model_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      drive_port(1'b0, 32'h8000_0040, 32'h0, 4'b0000);
      bad = 1'b1;
      for (int c = 0; c < 10 && bad; c++) begin
         @(negedge clk);
         if (m_valid) bad = 1'b0;
      end
      check("busy before reset", 32'(bad), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      s_valid = 2'b00;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid-busy reset m_valid", 32'(m_valid), 32'd0);
      check("mid-busy reset s_ready", 32'(s_ready), 32'd0);
      check("mid-busy reset grant", 32'(grant), 32'd0);

      // Both ports request continuously; reset pointer means port 0 first
      model_lat = 2;
      model_rdata = 32'h0;
      @(posedge clk); #1;
      drive_port(1'b0, 32'h8000_0200, 32'h0, 4'b0000);
      drive_port(1'b1, 32'h8000_0300, 32'h0, 4'b0000);
      npulse = 0; cnt0 = 0; cnt1 = 0; bad = 1'b0;
      for (int i = 0; i < 4; i++) seq[i] = -1;
      for (int c = 0; c < 200 && npulse < 4; c++) begin
         @(negedge clk);
         if (s_ready == 2'b11) bad = 1'b1;
         if (s_ready[0]) begin seq[npulse] = 0; cnt0++; npulse++; end
         else if (s_ready[1]) begin seq[npulse] = 1; cnt1++; npulse++; end
      end
      @(posedge clk); #1;
      s_valid = 2'b00;
      for (int i = 0; i < 4; i++) check($sformatf("rr grant seq[%0d]", i), seq[i], 32'(i % 2));
      check("rr port0 pulses", cnt0, 32'd2);
      check("rr port1 pulses", cnt1, 32'd2);
      check("rr never both ready", 32'(bad), 32'd0);
      repeat (3) @(negedge clk);
      check("idle after rr", 32'({m_valid, s_ready}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
